hamming74_serial_tx: RTL and testbench

Hamming(7,4) encoder and serializer, the transmit end of the Hamming link whose receiver uses a 3-to-8 syndrome decoder.
- Accepts a 4-bit data nibble on a valid/ready handshake and computes the 7-bit codeword.
- Presents the codeword in parallel.
- Shifts the codeword out one bit per BIT_PERIOD cycles, position 1 first, so syndrome value k at the receiver names bit position k.

---
 rtl/hamming74_serial_tx.sv | 133 +++++++++++++
 tb/tb_hamming74_serial_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming74_serial_tx.sv
// Hamming(7,4) encoder with a parallel codeword output and a position-1-first serializer.
// Define HAMM_SECDED_EN to build the extended Hamming(8,4) variant with an overall parity bit at position 8.
module hamming74_serial_tx #(
   parameter int unsigned BIT_PERIOD = 1,
   parameter int unsigned CNT_W      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] data_in,
   input  logic       in_valid,
   output logic       in_ready,
`ifdef HAMM_SECDED_EN
   output logic [1:8] code_out,
`else
   output logic [1:7] code_out,
`endif
   output logic       code_valid,
   output logic       ser_out,
   output logic       ser_valid,
   output logic       ser_first,
   output logic       ser_last
);

`ifdef HAMM_SECDED_EN
   localparam int unsigned CODE_W = 8;
`else
   localparam int unsigned CODE_W = 7;
`endif
   localparam int unsigned        POS_W    = 4;
   localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(BIT_PERIOD - 1);
   localparam logic [POS_W-1:0]   LAST_POS = POS_W'(CODE_W);
   localparam logic [POS_W-1:0]   ONE_POS  = POS_W'(1);
   localparam logic [CNT_W-1:0]   ONE_CNT  = CNT_W'(1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t             state;
   logic [POS_W-1:0]   pos;
   logic [CNT_W-1:0]   cnt;
   logic [1:CODE_W]    shreg;

   logic [1:CODE_W]    word_c;
   logic               accept_c;
   logic               bit_end_c;
   logic [POS_W-1:0]   pos_inc_c;
   logic [CNT_W-1:0]   cnt_inc_c;

   // Even-parity encode; index of the result is the Hamming bit position.
   function automatic logic [1:CODE_W] encode(input logic [3:0] d);
      logic [1:CODE_W] w;
      w    = '0;
      w[3] = d[0];
      w[5] = d[1];
      w[6] = d[2];
      w[7] = d[3];
      w[1] = d[0] ^ d[1] ^ d[3];
      w[2] = d[0] ^ d[2] ^ d[3];
      w[4] = d[1] ^ d[2] ^ d[3];
`ifdef HAMM_SECDED_EN
      w[8] = ^w[1:7];
`endif
      return w;
   endfunction

   assign word_c    = encode(data_in);
   assign accept_c  = in_valid & in_ready;
   assign bit_end_c = (cnt == LAST_CNT);
   assign pos_inc_c = pos + ONE_POS;
   assign cnt_inc_c = cnt + ONE_CNT;

   // Frame FSM; shreg holds the not-yet-sent positions with the next one at index 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         pos        <= '0;
         cnt        <= '0;
         shreg      <= '0;
         in_ready   <= 1'b0;
         code_out   <= '0;
         code_valid <= 1'b0;
         ser_out    <= 1'b0;
         ser_valid  <= 1'b0;
         ser_first  <= 1'b0;
         ser_last   <= 1'b0;
      end else begin
         code_valid <= 1'b0;
         if (accept_c) begin
            state      <= SHIFT;
            pos        <= ONE_POS;
            cnt        <= '0;
            code_out   <= word_c;
            code_valid <= 1'b1;
            shreg      <= word_c << 1;
            ser_out    <= word_c[1];
            ser_valid  <= 1'b1;
            ser_first  <= 1'b1;
            ser_last   <= 1'b0;
            in_ready   <= 1'b0;
         end else if (state == IDLE) begin
            pos       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_first <= 1'b0;
            ser_last  <= 1'b0;
         end else if (bit_end_c) begin
            cnt <= '0;
            if (pos == LAST_POS) begin
               // No back-to-back accept in the final cycle: frame ends.
               state     <= IDLE;
               pos       <= '0;
               in_ready  <= 1'b1;
               ser_out   <= 1'b0;
               ser_valid <= 1'b0;
               ser_first <= 1'b0;
               ser_last  <= 1'b0;
            end else begin
               pos       <= pos_inc_c;
               shreg     <= shreg << 1;
               ser_out   <= shreg[1];
               ser_first <= 1'b0;
               ser_last  <= (pos_inc_c == LAST_POS);
               in_ready  <= (pos_inc_c == LAST_POS) && (LAST_CNT == '0);
            end
         end else begin
            cnt      <= cnt_inc_c;
            in_ready <= (pos == LAST_POS) && (cnt_inc_c == LAST_CNT);
         end
      end
   end

endmodule

// File: tb/tb_hamming74_serial_tx.sv
// Self-checking bench for hamming74_serial_tx: one instance at BIT_PERIOD=1 and one at BIT_PERIOD=3,
// checked against a position-rule Hamming model and a syndrome calculator.
module tb_hamming74_serial_tx;

`ifdef HAMM_SECDED_EN
   localparam int CW = 8;
`else
   localparam int CW = 7;
`endif

   logic clk, rst;

   logic          v1, r1, cv1, so1, sv1, sf1, sl1;
   logic [3:0]    d1;
   logic [1:CW]   c1;
   logic          v3, r3, cv3, so3, sv3, sf3, sl3;
   logic [3:0]    d3;
   logic [1:CW]   c3;

   logic          o_ready, o_cv, o_so, o_sv, o_sf, o_sl;
   logic [1:CW]   o_code;

   int total = 0;
   int bad   = 0;
   int mw [9];

   hamming74_serial_tx #(.BIT_PERIOD(1), .CNT_W(8)) dut1 (
      .clk(clk), .rst(rst), .data_in(d1), .in_valid(v1), .in_ready(r1),
      .code_out(c1), .code_valid(cv1), .ser_out(so1), .ser_valid(sv1),
      .ser_first(sf1), .ser_last(sl1));

   hamming74_serial_tx #(.BIT_PERIOD(3), .CNT_W(8)) dut3 (
      .clk(clk), .rst(rst), .data_in(d3), .in_valid(v3), .in_ready(r3),
      .code_out(c3), .code_valid(cv3), .ser_out(so3), .ser_valid(sv3),
      .ser_first(sf3), .ser_last(sl3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sample(input int sel);
      if (sel == 0) begin
         o_ready = r1; o_code = c1; o_cv = cv1; o_so = so1; o_sv = sv1; o_sf = sf1; o_sl = sl1;
      end else begin
         o_ready = r3; o_code = c3; o_cv = cv3; o_so = so3; o_sv = sv3; o_sf = sf3; o_sl = sl3;
      end
   endtask

   task automatic drive(input int sel, input logic v, input logic [3:0] d);
      if (sel == 0) begin v1 = v; d1 = d; end
      else begin v3 = v; d3 = d; end
   endtask

   // Data goes to the non-power-of-two positions; parity at 2^j covers every position with bit j set.
   task automatic encode_model(input logic [3:0] d);
      int dpos [4];
      dpos = '{3, 5, 6, 7};
      for (int k = 0; k < 9; k++) mw[k] = 0;
      for (int i = 0; i < 4; i++) mw[dpos[i]] = int'(d[i]);
      for (int j = 0; j < 3; j++) begin
         int p;
         p = 1 << j;
         for (int k = 1; k <= 7; k++)
            if (k != p && (k & p) != 0) mw[p] = mw[p] ^ mw[k];
      end
      if (CW == 8)
         for (int k = 1; k <= 7; k++) mw[8] = mw[8] ^ mw[k];
   endtask

   function automatic int pack_model();
      int val;
      val = 0;
      for (int k = 1; k <= CW; k++) val = (val << 1) | mw[k];
      return val;
   endfunction

   function automatic int synd(input logic [1:CW] w);
      int s;
      s = 0;
      for (int k = 1; k <= 7; k++) if (w[k]) s = s ^ k;
      return s;
   endfunction

   task automatic syndrome_checks(input logic [1:CW] w);
      logic [1:CW] f;
      chk("syndrome_clean", 32'(synd(w)), 32'd0);
      if (CW == 8) chk("overall_parity", 32'(^w), 32'd0);
      for (int k = 1; k <= 7; k++) begin
         f = w;
         f[k] = ~f[k];
         chk("syndrome_flip", 32'(synd(f)), 32'(k));
      end
   endtask

   task automatic chk_all_zero(input int sel);
      sample(sel);
      chk("rst_ready", 32'(o_ready), 32'd0);
      chk("rst_code", 32'(o_code), 32'd0);
      chk("rst_code_valid", 32'(o_cv), 32'd0);
      chk("rst_ser_out", 32'(o_so), 32'd0);
      chk("rst_ser_valid", 32'(o_sv), 32'd0);
      chk("rst_ser_first", 32'(o_sf), 32'd0);
      chk("rst_ser_last", 32'(o_sl), 32'd0);
   endtask

   // One full frame checked cycle by cycle; chained means it was accepted on the edge just passed.
   task automatic frame(input int sel, input logic [3:0] d, input bit chained, input bit hold,
                        input bit chain_next, input logic [3:0] next_d);
      int bp, exp;
      bp = (sel == 0) ? 1 : 3;
      if (!chained) begin
         sample(sel);
         chk("ready_before_accept", 32'(o_ready), 32'd1);
         drive(sel, 1'b1, d);
         @(negedge clk);
      end
      encode_model(d);
      exp = pack_model();
      drive(sel, hold, hold ? next_d : 4'h0);
      for (int b = 1; b <= CW; b++) begin
         for (int c = 0; c < bp; c++) begin
            bit fin;
            fin = (b == CW) && (c == bp - 1);
            sample(sel);
            chk("code_out", 32'(o_code), 32'(exp));
            chk("code_valid", 32'(o_cv), 32'((b == 1) && (c == 0)));
            chk("ser_valid", 32'(o_sv), 32'd1);
            chk("ser_out", 32'(o_so), 32'(mw[b]));
            chk("ser_first", 32'(o_sf), 32'(b == 1));
            chk("ser_last", 32'(o_sl), 32'(b == CW));
            chk("in_ready", 32'(o_ready), 32'(fin));
            if (b == 1 && c == 0) syndrome_checks(o_code);
            if (fin) drive(sel, chain_next, next_d);
            @(negedge clk);
         end
      end
      if (!chain_next) begin
         sample(sel);
         chk("idle_ser_valid", 32'(o_sv), 32'd0);
         chk("idle_ser_out", 32'(o_so), 32'd0);
         chk("idle_ready", 32'(o_ready), 32'd1);
         chk("idle_code_valid", 32'(o_cv), 32'd0);
         chk("idle_code_hold", 32'(o_code), 32'(exp));
      end
   endtask

   initial begin
      logic [3:0] cur, nxt;
      bit cn, chained, hold;
      logic [1:CW] k1011, k0001, k1111;
`ifdef HAMM_SECDED_EN
      k1011 = 8'b10101010; k0001 = 8'b11100001; k1111 = 8'b11111111;
`else
      k1011 = 7'b1010101;  k0001 = 7'b1110000;  k1111 = 7'b1111111;
`endif
      rst = 1'b1;
      drive(0, 1'b0, 4'h0);
      drive(1, 1'b0, 4'h0);
      #3;
      chk_all_zero(0);
      chk_all_zero(1);
      #9 rst = 1'b0;
      @(negedge clk);
      sample(0);
      chk("ready_after_reset", 32'(o_ready), 32'd1);
      chk("ser_valid_after_reset", 32'(o_sv), 32'd0);
      chk("ser_out_after_reset", 32'(o_so), 32'd0);

      // Directed encodes at BIT_PERIOD=1
      frame(0, 4'b1011, 1'b0, 1'b0, 1'b0, 4'h0);
      sample(0);
      chk("const_1011", 32'(o_code), 32'(k1011));
      frame(0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'h0);
      sample(0);
      chk("const_0001", 32'(o_code), 32'(k0001));

      // Back-to-back with in_valid held high throughout
      frame(0, 4'b0001, 1'b0, 1'b1, 1'b1, 4'b1111);
      frame(0, 4'b1111, 1'b1, 1'b0, 1'b0, 4'h0);
      sample(0);
      chk("const_1111", 32'(o_code), 32'(k1111));

      // All 16 nibbles, chained
      chained = 1'b0;
      for (int n = 0; n < 16; n++) begin
         cn = (n != 15);
         frame(0, 4'(n), chained, 1'b0, cn, 4'(n + 1));
         chained = cn;
      end

      // Async reset mid-sim, away from the clock edge
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk_all_zero(0);
      chk_all_zero(1);
      #1 rst = 1'b0;
      @(negedge clk);
      sample(0);
      chk("ready_after_midreset", 32'(o_ready), 32'd1);
      chk("ser_valid_after_midreset", 32'(o_sv), 32'd0);

      // BIT_PERIOD=3 full frame, then abort at cycle 10
      frame(1, 4'b1011, 1'b0, 1'b0, 1'b0, 4'h0);
      drive(1, 1'b1, 4'b1011);
      @(negedge clk);
      drive(1, 1'b0, 4'h0);
      for (int c = 2; c <= 10; c++) @(negedge clk);
      sample(1);
      chk("abort_pre_ser_valid", 32'(o_sv), 32'd1);
      #2 rst = 1'b1;
      #1;
      sample(1);
      chk("abort_ser_valid", 32'(o_sv), 32'd0);
      chk("abort_ser_out", 32'(o_so), 32'd0);
      chk("abort_ready", 32'(o_ready), 32'd0);
      #1 rst = 1'b0;
      @(negedge clk);
      sample(1);
      chk("abort_ready_release", 32'(o_ready), 32'd1);
      chk("abort_no_ser_valid", 32'(o_sv), 32'd0);
      @(negedge clk);
      sample(1);
      chk("abort_still_idle", 32'(o_sv), 32'd0);
      frame(1, 4'b1011, 1'b0, 1'b0, 1'b0, 4'h0);

      // Random frames on both instances
      for (int sel = 0; sel < 2; sel++) begin
         cur = 4'($urandom_range(0, 15));
         chained = 1'b0;
         for (int i = 0; i < 6; i++) begin
            nxt  = 4'($urandom_range(0, 15));
            cn   = (i != 5) ? 1'($urandom_range(0, 1)) : 1'b0;
            hold = 1'($urandom_range(0, 1)) & cn;
            frame(sel, cur, chained, hold, cn, nxt);
            chained = cn;
            cur = nxt;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
